// File: rtl/pzcorebus_response_order_demux_if.sv
// Response channel of the corebus. The demux uses it in both directions:
// as master toward the upstream ports and as slave toward the downstream port.
interface pzcorebus_response_order_demux_if #(
    parameter int ID_WIDTH     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int INFO_WIDTH   = 2,
    parameter int UNITEN_WIDTH = 4
);
    logic                    sresp_valid;
    logic                    mresp_accept;
    logic [1:0]              sresp;
    logic [ID_WIDTH-1:0]     sid;
    logic                    serror;
    logic [DATA_WIDTH-1:0]   sdata;
    logic [INFO_WIDTH-1:0]   sinfo;
    logic [UNITEN_WIDTH-1:0] sresp_uniten;
    logic                    sresp_last;

    modport response_master (
        output sresp_valid, sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last,
        input  mresp_accept
    );

    modport response_slave (
        input  sresp_valid, sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last,
        output mresp_accept
    );
endinterface

// File: rtl/pzcorebus_response_order_demux.sv
// Records the owner port of every forwarded non-posted command and steers the
// downstream response bursts back to those owners in command order.
module pzcorebus_response_order_demux #(
    parameter int SLAVES      = 2,
    parameter int DEPTH       = 4,
    parameter int INDEX_WIDTH = $clog2(SLAVES)
)(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_command_valid,
    input  logic                       i_command_accept,
    input  logic                       i_command_non_posted,
    input  logic [INDEX_WIDTH-1:0]     i_command_index,
    output logic                       o_command_stall,
    output logic                       o_unexpected_response,
    output logic [$clog2(DEPTH+1)-1:0] o_outstanding,
    pzcorebus_response_order_demux_if.response_master slave_if[SLAVES],
    pzcorebus_response_order_demux_if.response_slave  master_if
);
    localparam int COUNT_WIDTH   = $clog2(DEPTH + 1);
    localparam int POINTER_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INDEX_WIDTH-1:0]   order_fifo [DEPTH];
    logic [POINTER_WIDTH-1:0] write_pointer;
    logic [POINTER_WIDTH-1:0] read_pointer;
    logic [COUNT_WIDTH-1:0]   count;
    logic [INDEX_WIDTH-1:0]   head;
    logic [SLAVES-1:0]        slave_accept;
    logic                     empty;
    logic                     full;
    logic                     push;
    logic                     pop;
    logic                     unexpected;

    assign empty = (count == '0);
    assign full  = (count == COUNT_WIDTH'(DEPTH));
    assign head  = order_fifo[read_pointer];

    assign push = i_command_valid && i_command_accept && i_command_non_posted && !full;
    assign pop  = master_if.sresp_valid && master_if.mresp_accept && master_if.sresp_last;

    assign o_command_stall       = full;
    assign o_outstanding         = count;
    assign o_unexpected_response = unexpected;

    // Payload is broadcast; only the head owner sees valid.
    for (genvar k = 0; k < SLAVES; k++) begin : g_slave
        assign slave_if[k].sresp_valid  = master_if.sresp_valid && !empty && (head == INDEX_WIDTH'(k));
        assign slave_if[k].sresp        = master_if.sresp;
        assign slave_if[k].sid          = master_if.sid;
        assign slave_if[k].serror       = master_if.serror;
        assign slave_if[k].sdata        = master_if.sdata;
        assign slave_if[k].sinfo        = master_if.sinfo;
        assign slave_if[k].sresp_uniten = master_if.sresp_uniten;
        assign slave_if[k].sresp_last   = master_if.sresp_last;
        assign slave_accept[k]          = slave_if[k].mresp_accept;
    end

    assign master_if.mresp_accept = slave_accept[head] && !empty;

    // NOTE: the order storage carries no reset; an entry is only read after it is written,
    // and occupancy alone decides whether the head is meaningful.
    always_ff @(posedge i_clk) begin
        if (push) begin
            order_fifo[write_pointer] <= i_command_index;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            count         <= '0;
            unexpected    <= 1'b0;
        end else begin
            if (push) begin
                write_pointer <= (write_pointer == POINTER_WIDTH'(DEPTH - 1)) ? '0 : write_pointer + 1'b1;
            end
            if (pop) begin
                read_pointer <= (read_pointer == POINTER_WIDTH'(DEPTH - 1)) ? '0 : read_pointer + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (master_if.sresp_valid && empty) begin
                unexpected <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pzcorebus_response_order_demux.sv
// Directed bench for the response order demux with four upstream ports and a
// four-entry order FIFO.
module tb_pzcorebus_response_order_demux;
    localparam int SLAVES = 4;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_accept;
    logic       cmd_non_posted;
    logic [1:0] cmd_index;
    logic       stall;
    logic       unexpected;
    logic [2:0] outstanding;

    logic [SLAVES-1:0] up_accept;
    logic [SLAVES-1:0] obs_valid;
    logic [31:0]       obs_data [SLAVES];

    int checks = 0;
    int errors = 0;

    pzcorebus_response_order_demux_if slave_if[SLAVES] ();
    pzcorebus_response_order_demux_if master_if ();

    for (genvar k = 0; k < SLAVES; k++) begin : g_up
        assign slave_if[k].mresp_accept = up_accept[k];
        assign obs_valid[k]             = slave_if[k].sresp_valid;
        assign obs_data[k]              = slave_if[k].sdata;
    end

    pzcorebus_response_order_demux #(
        .SLAVES (SLAVES),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_command_valid       (cmd_valid),
        .i_command_accept      (cmd_accept),
        .i_command_non_posted  (cmd_non_posted),
        .i_command_index       (cmd_index),
        .o_command_stall       (stall),
        .o_unexpected_response (unexpected),
        .o_outstanding         (outstanding),
        .slave_if              (slave_if),
        .master_if             (master_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] index, input logic non_posted);
        cmd_valid      = 1'b1;
        cmd_accept     = 1'b1;
        cmd_non_posted = non_posted;
        cmd_index      = index;
        tick();
        cmd_valid      = 1'b0;
        cmd_non_posted = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic last);
        master_if.sresp_valid = 1'b1;
        master_if.sdata       = data;
        master_if.sresp_last  = last;
    endtask

    task automatic idle_resp();
        master_if.sresp_valid = 1'b0;
        master_if.sresp_last  = 1'b0;
    endtask

    initial begin
        logic [1:0]  order_port  [4];
        logic [2:0]  order_count [4];
        logic [31:0] data;

        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_accept     = 1'b0;
        cmd_non_posted = 1'b0;
        cmd_index      = '0;
        up_accept      = '1;
        master_if.sresp_valid  = 1'b0;
        master_if.sresp        = '0;
        master_if.sid          = '0;
        master_if.serror       = 1'b0;
        master_if.sdata        = '0;
        master_if.sinfo        = '0;
        master_if.sresp_uniten = '0;
        master_if.sresp_last   = 1'b0;
        tick();
        tick();
        check("reset_outstanding", outstanding, 0);
        check("reset_stall", stall, 0);
        check("reset_unexpected", unexpected, 0);
        check("reset_accept", master_if.mresp_accept, 0);
        check("reset_valid", obs_valid, 0);
        rst = 1'b0;
        tick();

        // Single read: 4-beat burst back to port 1.
        send_cmd(2'd1, 1'b1);
        check("single_outstanding", outstanding, 1);
        for (int beat = 0; beat < 4; beat++) begin
            data = 32'hA000_0000 + 32'(beat);
            drive_beat(data, beat == 3);
            #1;
            check("single_valid", obs_valid, 4'b0010);
            check("single_accept", master_if.mresp_accept, 1);
            check("single_data", obs_data[1], data);
            check("single_held_count", outstanding, 1);
            tick();
        end
        idle_resp();
        check("single_pop", outstanding, 0);

        // Ordering and full/stall.
        send_cmd(2'd2, 1'b1);
        send_cmd(2'd0, 1'b1);
        send_cmd(2'd3, 1'b1);
        send_cmd(2'd2, 1'b1);
        check("full_outstanding", outstanding, 4);
        check("full_stall", stall, 1);
        send_cmd(2'd3, 1'b1);
        check("blocked_push_count", outstanding, 4);

        drive_beat(32'h0000_000A, 1'b1);
        #1;
        check("order_A_valid", obs_valid, 4'b0100);
        tick();
        idle_resp();
        check("stall_drop_count", outstanding, 3);
        check("stall_drop", stall, 0);
        send_cmd(2'd1, 1'b1);
        check("refill_count", outstanding, 4);
        check("refill_stall", stall, 1);

        order_port  = '{2'd0, 2'd3, 2'd2, 2'd1};
        order_count = '{3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 4; i++) begin
            data = 32'h0000_00B0 + 32'(i);
            drive_beat(data, 1'b1);
            #1;
            check("order_count", outstanding, order_count[i]);
            check("order_valid", obs_valid, 4'b0001 << order_port[i]);
            check("order_data", obs_data[order_port[i]], data);
            tick();
        end
        idle_resp();
        check("order_drained", outstanding, 0);

        // Posted commands are not recorded.
        send_cmd(2'd0, 1'b0);
        send_cmd(2'd2, 1'b0);
        send_cmd(2'd3, 1'b0);
        check("posted_count", outstanding, 0);
        send_cmd(2'd1, 1'b1);
        check("posted_np_count", outstanding, 1);
        drive_beat(32'h0000_0C01, 1'b1);
        #1;
        check("posted_valid", obs_valid, 4'b0010);
        tick();
        idle_resp();
        check("posted_drained", outstanding, 0);

        // Backpressure from the head port.
        send_cmd(2'd3, 1'b1);
        up_accept = 4'b0111;
        drive_beat(32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_accept", master_if.mresp_accept, 0);
            check("bp_valid", obs_valid, 4'b1000);
            check("bp_data", obs_data[3], 32'hDEAD_BEEF);
            tick();
            check("bp_count", outstanding, 1);
        end
        up_accept = '1;
        #1;
        check("bp_release_accept", master_if.mresp_accept, 1);
        tick();
        idle_resp();
        check("bp_drained", outstanding, 0);

        // Simultaneous push and pop.
        send_cmd(2'd0, 1'b1);
        drive_beat(32'h0000_5150, 1'b1);
        cmd_valid      = 1'b1;
        cmd_accept     = 1'b1;
        cmd_non_posted = 1'b1;
        cmd_index      = 2'd2;
        #1;
        check("sim_valid", obs_valid, 4'b0001);
        tick();
        cmd_valid      = 1'b0;
        cmd_non_posted = 1'b0;
        check("sim_count", outstanding, 1);
        #1;
        check("sim_next_valid", obs_valid, 4'b0100);
        tick();
        idle_resp();
        check("sim_drained", outstanding, 0);

        // Unexpected response on an empty FIFO.
        drive_beat(32'h0000_0BAD, 1'b1);
        #1;
        check("err_accept", master_if.mresp_accept, 0);
        check("err_valid", obs_valid, 0);
        check("err_not_yet", unexpected, 0);
        tick();
        check("err_set", unexpected, 1);
        idle_resp();
        tick();
        check("err_sticky", unexpected, 1);
        check("err_count", outstanding, 0);

        // Reset mid-burst.
        send_cmd(2'd2, 1'b1);
        drive_beat(32'h0000_1111, 1'b0);
        tick();
        check("mid_burst_count", outstanding, 1);
        rst = 1'b1;
        tick();
        check("rst_outstanding", outstanding, 0);
        check("rst_stall", stall, 0);
        check("rst_unexpected", unexpected, 0);
        check("rst_accept", master_if.mresp_accept, 0);
        check("rst_valid", obs_valid, 0);
        idle_resp();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_count", outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
